branch_resolve_queue: RTL and testbench

//  In-order queue of fetched branches awaiting resolution; sits between fetch/execute and branch_predictor.

---
 rtl/branch_pkg.sv | 17 +
 rtl/brq_ptr.sv | 43 ++++
 rtl/branch_resolve_queue.sv | 135 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve queue: default widths, entry field
// widths (entry layout {pc, predict, target}), PC step and statistics sizing.
package branch_pkg;

   localparam int unsigned BRQ_DEPTH = 4;
   localparam int unsigned BRQ_PC_W  = 32;
   localparam int unsigned PREDICT_W = 1;
   localparam int unsigned PC_STEP   = 4;
   localparam int unsigned STAT_W    = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   // Packed width of one {pc, predict, target} entry for a given PC width.
   function automatic int unsigned entry_w(input int unsigned pc_w);
      return 2 * pc_w + PREDICT_W;
   endfunction

endpackage

// File: rtl/brq_ptr.sv
// Wrap-around head/tail/occupancy tracker for the branch resolve queue.
// clear discards every entry and restarts the queue just past the current head.
module brq_ptr #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   output logic [$clog2(DEPTH)-1:0]   head,
   output logic [$clog2(DEPTH)-1:0]   tail,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] head_inc;

   assign head_inc = head + AW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= head_inc;
         tail  <= head_inc;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head_inc;
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the oldest, updates the predictor
// and flushes on mispredict. Optional statistics counters: define BRQ_STATS_EN.
module branch_resolve_queue
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = BRQ_DEPTH,
   parameter int unsigned PC_W  = BRQ_PC_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enq_valid,
   input  logic [PC_W-1:0]         enq_pc,
   input  logic                    enq_predict,
   input  logic [PC_W-1:0]         enq_target,
   output logic                    enq_ready,
   input  logic                    res_valid,
   input  logic                    res_taken,
   input  logic [PC_W-1:0]         res_target,
   output logic                    upd_write,
   output logic [PC_W-1:0]         upd_pc,
   output logic                    upd_result,
   output logic [PC_W-1:0]         upd_address,
   output logic                    flush,
   output logic [PC_W-1:0]         redirect_pc,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    underflow,
   output logic [STAT_W-1:0]       stat_resolved,
   output logic [STAT_W-1:0]       stat_mispredict
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam int unsigned ENTRY_W = entry_w(PC_W);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            predict;
      logic [PC_W-1:0] target;
   } brq_entry_t;

   logic [ENTRY_W-1:0] mem [DEPTH];
   brq_entry_t         head_e;
   brq_entry_t         new_e;
   logic [AW-1:0]      head;
   logic [AW-1:0]      tail;
   logic [CW-1:0]      occ;
   logic               empty;
   logic               enq_fire;
   logic               res_fire;
   logic               mispredict;
   logic               flush_fire;

   assign empty     = (occ == '0);
   assign enq_ready = (occ != CW'(DEPTH));
   assign enq_fire  = enq_valid & enq_ready;
   assign res_fire  = res_valid & ~empty;
   assign head_e    = brq_entry_t'(mem[head]);
   assign count     = occ;

   always_comb begin
      new_e         = '0;
      new_e.pc      = enq_pc;
      new_e.predict = enq_predict;
      new_e.target  = enq_target;
   end

   always_comb begin
      mispredict = (res_taken != head_e.predict)
                 | (res_taken & head_e.predict & (res_target != head_e.target));
   end

   assign flush_fire = res_fire & mispredict;

   // A same-cycle enqueue during a flush is wrong-path and is not allowed to land.
   brq_ptr #(.DEPTH(DEPTH)) u_ptr (
      .clock (clock),
      .reset (reset),
      .push  (enq_fire & ~flush_fire),
      .pop   (res_fire),
      .clear (flush_fire),
      .head  (head),
      .tail  (tail),
      .count (occ)
   );

   always_ff @(posedge clock) begin
      if (enq_fire & ~flush_fire) mem[tail] <= new_e;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         upd_write   <= 1'b0;
         upd_pc      <= '0;
         upd_result  <= 1'b0;
         upd_address <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         underflow   <= 1'b0;
      end else begin
         upd_write <= res_fire;
         flush     <= flush_fire;
         if (res_fire) begin
            upd_pc      <= head_e.pc;
            upd_result  <= res_taken;
            upd_address <= res_target;
         end
         if (flush_fire) begin
            redirect_pc <= res_taken ? res_target : head_e.pc + PC_W'(PC_STEP);
         end
         if (res_valid & empty) underflow <= 1'b1;
      end
   end

`ifdef BRQ_STATS_EN
   logic [STAT_W-1:0] resolved_q;
   logic [STAT_W-1:0] mispredict_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resolved_q   <= '0;
         mispredict_q <= '0;
      end else begin
         if (res_fire && resolved_q != STAT_MAX)     resolved_q   <= resolved_q + STAT_W'(1);
         if (flush_fire && mispredict_q != STAT_MAX) mispredict_q <= mispredict_q + STAT_W'(1);
      end
   end

   assign stat_resolved   = resolved_q;
   assign stat_mispredict = mispredict_q;
`else
   assign stat_resolved   = '0;
   assign stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: queue-based reference model checked
// every cycle, directed literal checks, then randomized traffic.
module tb_branch_resolve_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PC_W  = 32;

   logic        clock;
   logic        reset;
   logic        enq_valid;
   logic [31:0] enq_pc;
   logic        enq_predict;
   logic [31:0] enq_target;
   logic        enq_ready;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        upd_write;
   logic [31:0] upd_pc;
   logic        upd_result;
   logic [31:0] upd_address;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [2:0]  count;
   logic        underflow;
   logic [15:0] stat_resolved;
   logic [15:0] stat_mispredict;

   branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clock           (clock),
      .reset           (reset),
      .enq_valid       (enq_valid),
      .enq_pc          (enq_pc),
      .enq_predict     (enq_predict),
      .enq_target      (enq_target),
      .enq_ready       (enq_ready),
      .res_valid       (res_valid),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .upd_write       (upd_write),
      .upd_pc          (upd_pc),
      .upd_result      (upd_result),
      .upd_address     (upd_address),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
      .count           (count),
      .underflow       (underflow),
      .stat_resolved   (stat_resolved),
      .stat_mispredict (stat_mispredict)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic [31:0] tgt;
   } ent_t;

   ent_t        q[$];
   logic        e_write, e_result, e_flush, e_under;
   logic [31:0] e_pc, e_addr, e_redir;
   int          e_sres, e_smis;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      e_write = 0; e_result = 0; e_flush = 0; e_under = 0;
      e_pc = 0; e_addr = 0; e_redir = 0;
      e_sres = 0; e_smis = 0;
   endtask

   // Applies the queue rules to the inputs present at this rising edge.
   task automatic model_step();
      ent_t h;
      bit   ready;
      bit   mis;
      if (reset) begin
         model_reset();
         return;
      end
      ready   = (q.size() < DEPTH);
      mis     = 0;
      e_write = 0;
      e_flush = 0;
      if (res_valid) begin
         if (q.size() == 0) begin
            e_under = 1;
         end else begin
            h        = q.pop_front();
            e_write  = 1;
            e_pc     = h.pc;
            e_result = res_taken;
            e_addr   = res_target;
            mis = (res_taken != h.pred) || (res_taken && h.pred && res_target != h.tgt);
            if (e_sres < 65535) e_sres++;
            if (mis) begin
               e_flush = 1;
               e_redir = res_taken ? res_target : h.pc + 32'd4;
               q.delete();
               if (e_smis < 65535) e_smis++;
            end
         end
      end
      if (enq_valid && ready && !mis) begin
         h.pc = enq_pc; h.pred = enq_predict; h.tgt = enq_target;
         q.push_back(h);
      end
   endtask

   always @(posedge clock) begin
      model_step();
      #1;
      chk("enq_ready", enq_ready, (q.size() < DEPTH) ? 1 : 0);
      chk("count", count, q.size());
      chk("upd_write", upd_write, e_write);
      chk("upd_pc", upd_pc, e_pc);
      chk("upd_result", upd_result, e_result);
      chk("upd_address", upd_address, e_addr);
      chk("flush", flush, e_flush);
      chk("redirect_pc", redirect_pc, e_redir);
      chk("underflow", underflow, e_under);
`ifdef BRQ_STATS_EN
      chk("stat_resolved", stat_resolved, e_sres);
      chk("stat_mispredict", stat_mispredict, e_smis);
`else
      chk("stat_resolved", stat_resolved, 0);
      chk("stat_mispredict", stat_mispredict, 0);
`endif
   end

   task automatic cyc(input logic ev, input logic [31:0] pc, input logic pr, input logic [31:0] tg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
      enq_valid = ev; enq_pc = pc; enq_predict = pr; enq_target = tg;
      res_valid = rv; res_taken = rt; res_target = rtg;
      @(negedge clock);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      cyc(0, 0, 0, 0, 0, 0, 0);
      idle();
      reset = 1'b0;
   endtask

   initial begin
      logic        ev, pr, rv, rt;
      logic [31:0] pc, tg, rtg;
      enq_valid = 0; enq_pc = 0; enq_predict = 0; enq_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("lit_reset_ready", enq_ready, 1);
      chk("lit_reset_count", count, 0);

      // Single correctly predicted taken branch
      cyc(1, 32'h100, 1, 32'h200, 0, 0, 0);
      chk("lit_push_count", count, 1);
      cyc(0, 0, 0, 0, 1, 1, 32'h200);
      chk("lit_upd_write", upd_write, 1);
      chk("lit_upd_pc", upd_pc, 32'h100);
      chk("lit_upd_result", upd_result, 1);
      chk("lit_upd_address", upd_address, 32'h200);
      chk("lit_no_flush", flush, 0);
      idle();
      chk("lit_upd_pulse", upd_write, 0);

      // Fill, overflow attempt, drain in order
      for (int i = 0; i < 4; i++)
         cyc(1, 32'h1000 + 32'(i * 16), (i % 2 == 1), 32'h2000 + 32'(i * 16), 0, 0, 0);
      chk("lit_full_count", count, 4);
      chk("lit_full_ready", enq_ready, 0);
      cyc(1, 32'h9990, 1, 32'h9999, 0, 0, 0);
      chk("lit_full_drop", count, 4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 1, (i % 2 == 1), 32'h2000 + 32'(i * 16));
         chk("lit_drain_pc", upd_pc, 32'h1000 + 32'(i * 16));
         chk("lit_drain_flush", flush, 0);
      end
      chk("lit_drain_count", count, 0);

      // Direction mispredict discards younger entries
      cyc(1, 32'h300, 0, 32'h380, 0, 0, 0);
      cyc(1, 32'h310, 1, 32'h390, 0, 0, 0);
      cyc(1, 32'h320, 0, 32'h0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'h340);
      chk("lit_mis_flush", flush, 1);
      chk("lit_mis_redirect", redirect_pc, 32'h340);
      chk("lit_mis_count", count, 0);
      chk("lit_mis_upd_pc", upd_pc, 32'h300);
      idle();
      chk("lit_flush_pulse", flush, 0);
      chk("lit_redirect_hold", redirect_pc, 32'h340);
      idle();
      chk("lit_no_wrong_path", upd_write, 0);

      // Target mispredict, then not-taken mispredict
      cyc(1, 32'h400, 1, 32'h200, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'h204);
      chk("lit_tgt_flush", flush, 1);
      chk("lit_tgt_redirect", redirect_pc, 32'h204);
      cyc(1, 32'h500, 1, 32'h600, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 32'h0);
      chk("lit_nt_flush", flush, 1);
      chk("lit_nt_redirect", redirect_pc, 32'h504);

      // Resolve on empty queue
      idle();
      cyc(0, 0, 0, 0, 1, 1, 32'h800);
      chk("lit_empty_write", upd_write, 0);
      chk("lit_underflow", underflow, 1);
      idle(); idle(); idle();
      chk("lit_underflow_sticky", underflow, 1);

      // Statistics: 3 resolves, 1 mispredict
      do_reset();
      cyc(1, 32'h700, 1, 32'h710, 0, 0, 0);
      cyc(1, 32'h720, 0, 32'h0, 0, 0, 0);
      cyc(1, 32'h740, 1, 32'h750, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'h710);
      cyc(0, 0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 0, 32'h0);
      idle();
`ifdef BRQ_STATS_EN
      chk("lit_stat_resolved", stat_resolved, 3);
      chk("lit_stat_mispredict", stat_mispredict, 1);
`else
      chk("lit_stat_resolved", stat_resolved, 0);
      chk("lit_stat_mispredict", stat_mispredict, 0);
`endif

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         ev = ($urandom_range(0, 99) < 55);
         pc = $urandom & 32'hFFFF_FFFC;
         pr = 1'($urandom_range(0, 1));
         tg = $urandom & 32'hFFFF_FFFC;
         rv = ($urandom_range(0, 99) < 45);
         if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
            rt  = q[0].pred;
            rtg = q[0].tgt;
         end else begin
            rt  = 1'($urandom_range(0, 1));
            rtg = $urandom & 32'hFFFF_FFFC;
         end
         cyc(ev, pc, pr, tg, rv, rt, rtg);
      end

      // Asynchronous reset with an update pulse pending
      idle();
      cyc(1, 32'hA00, 1, 32'hA40, 0, 0, 0);
      cyc(1, 32'hA10, 0, 32'h0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'hA40);
      chk("lit_pre_reset_write", upd_write, 1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("lit_async_count", count, 0);
      chk("lit_async_write", upd_write, 0);
      chk("lit_async_upd_pc", upd_pc, 0);
      chk("lit_async_ready", enq_ready, 1);
      chk("lit_async_underflow", underflow, 0);
      @(negedge clock);
      reset = 1'b0;
      idle(); idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
